// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: load-beat stream plus the array-edge operand and control bus.
interface systolic_feeder_if #(
    parameter int N = 4,
    parameter int WIDTHx = 8
);
    logic in_valid;
    logic in_ready;
    logic [WIDTHx-1:0] in_a;
    logic [WIDTHx-1:0] in_b;
    logic [N*WIDTHx-1:0] row_a;
    logic [N*WIDTHx-1:0] col_b;
    logic arr_ena;
    logic arr_valid;
    logic done;
    modport master (
        output in_valid, in_a, in_b,
        input in_ready, row_a, col_b, arr_ena, arr_valid, done
    );
    modport slave (
        input in_valid, in_a, in_b,
        output in_ready, row_a, col_b, arr_ena, arr_valid, done
    );
endinterface

// File: rtl/systolic_feeder.sv
// systolic_feeder: stores A/B beats, clears the array, then feeds diagonally skewed operands.
module systolic_feeder #(
    parameter int N = 4,
    parameter int WIDTHx = 8
) (
    input logic clock,
    input logic nreset,
    systolic_feeder_if.slave bus
);
    localparam int KW = $clog2(N);
    localparam int TW = $clog2(3*N-2);
    localparam logic [TW-1:0] T_LAST = TW'(3*N-3);
    localparam logic [KW-1:0] K_LAST = KW'(N-1);
    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, FEED, DONE} state_t;
    state_t state, state_n;
    logic [KW-1:0] ld_r, ld_k, wr_r, wr_k;
    logic [TW-1:0] t;
    logic [WIDTHx-1:0] a_s [N][N];
    logic [WIDTHx-1:0] b_s [N][N];
    logic accept, last;
    assign accept = bus.in_valid && bus.in_ready;
    assign last = state == LOAD && ld_r == K_LAST && ld_k == K_LAST;
    // IDLE and DONE always start a fresh job at beat 0
    assign wr_r = state == LOAD ? ld_r : '0;
    assign wr_k = state == LOAD ? ld_k : '0;
    assign bus.in_ready = state == IDLE || state == LOAD || state == DONE;
    assign bus.arr_valid = state == LOAD || state == FEED || state == DONE;
    assign bus.arr_ena = state == FEED;
    assign bus.done = state == DONE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = accept ? LOAD : IDLE;
            LOAD: state_n = accept && last ? CLEAR : LOAD;
            CLEAR: state_n = FEED;
            FEED: state_n = t == T_LAST ? DONE : FEED;
            DONE: state_n = accept ? LOAD : DONE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or negedge nreset)
        if (!nreset) begin
            state <= IDLE;
            ld_r <= '0;
            ld_k <= '0;
            t <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_s[i][j] <= '0;
                    b_s[i][j] <= '0;
                end
        end else begin
            state <= state_n;
            t <= state == FEED ? t + 1'b1 : '0;
            if (accept) begin
                a_s[wr_r][wr_k] <= bus.in_a;
                b_s[wr_r][wr_k] <= bus.in_b;
                ld_k <= wr_k == K_LAST ? '0 : wr_k + 1'b1;
                ld_r <= wr_k == K_LAST ? wr_r + 1'b1 : wr_r;
            end
        end
    // lane r carries element t-r of its stored row/column; zero outside the skew window
    for (genvar r = 0; r < N; r++) begin : g_lane
        logic [TW-1:0] d;
        logic in_win;
        assign d = t - TW'(r);
        assign in_win = state == FEED && t >= TW'(r) && d < TW'(N);
        assign bus.row_a[r*WIDTHx +: WIDTHx] = in_win ? a_s[r][d[KW-1:0]] : '0;
        assign bus.col_b[r*WIDTHx +: WIDTHx] = in_win ? b_s[r][d[KW-1:0]] : '0;
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench with a behavioural N=2 and N=4 systolic array model.
module tb_systolic_feeder;
    logic clk = 0;
    logic nrst2 = 0;
    logic nrst4 = 0;
    always #5 clk = ~clk;
    systolic_feeder_if #(.N(2), .WIDTHx(8)) f2 ();
    systolic_feeder_if #(.N(4), .WIDTHx(8)) f4 ();
    systolic_feeder #(.N(2), .WIDTHx(8)) u2 (.clock(clk), .nreset(nrst2), .bus(f2.slave));
    systolic_feeder #(.N(4), .WIDTHx(8)) u4 (.clock(clk), .nreset(nrst4), .bus(f4.slave));
    int n_chk = 0;
    int n_fail = 0;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // behavioural array: a moves right, b moves down, one hop per cycle
    logic [31:0] z2 [2][2];
    logic [7:0] pa2 [2][2];
    logic [7:0] pb2 [2][2];
    always @(posedge clk)
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                logic [7:0] ai, bi;
                if (c == 0) ai = f2.row_a[r*8 +: 8]; else ai = pa2[r][c-1];
                if (r == 0) bi = f2.col_b[c*8 +: 8]; else bi = pb2[r-1][c];
                if (!f2.arr_valid) begin
                    z2[r][c] <= 0;
                    pa2[r][c] <= 0;
                    pb2[r][c] <= 0;
                end else if (f2.arr_ena) begin
                    z2[r][c] <= z2[r][c] + ai * bi;
                    pa2[r][c] <= ai;
                    pb2[r][c] <= bi;
                end
            end
    logic [31:0] z4 [4][4];
    logic [7:0] pa4 [4][4];
    logic [7:0] pb4 [4][4];
    always @(posedge clk)
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                logic [7:0] ai, bi;
                if (c == 0) ai = f4.row_a[r*8 +: 8]; else ai = pa4[r][c-1];
                if (r == 0) bi = f4.col_b[c*8 +: 8]; else bi = pb4[r-1][c];
                if (!f4.arr_valid) begin
                    z4[r][c] <= 0;
                    pa4[r][c] <= 0;
                    pb4[r][c] <= 0;
                end else if (f4.arr_ena) begin
                    z4[r][c] <= z4[r][c] + ai * bi;
                    pa4[r][c] <= ai;
                    pb4[r][c] <= bi;
                end
            end
    typedef logic [15:0][31:0] cmat_t;
    logic [63:0] fq4 [$];
    cmat_t cq4 [$];
    logic [31:0] q2 [$];
    logic [7:0] ma [4][4];
    logic [7:0] mb [4][4];
    logic done_q4 = 0;
    // N=4 monitor: every FEED cycle pops one skew vector, every rising done pops one C
    always @(negedge clk)
        if (nrst4) begin
            if (f4.arr_ena) begin
                check("feed_q_empty", fq4.size() == 0, 0);
                if (fq4.size() != 0) begin
                    logic [63:0] e;
                    e = fq4.pop_front();
                    check("row_a", f4.row_a, e[63:32]);
                    check("col_b", f4.col_b, e[31:0]);
                    check("feed_rdy", f4.in_ready, 0);
                end
            end
            if (f4.done && !done_q4) begin
                check("c_q_empty", cq4.size() == 0, 0);
                if (cq4.size() != 0) begin
                    cmat_t cm;
                    cm = cq4.pop_front();
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++)
                            check($sformatf("z4[%0d][%0d]", r, c), z4[r][c], cm[r*4+c]);
                end
            end
            done_q4 = f4.done;
        end
    task automatic set_job(input int kind);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (kind == 0) begin
                    ma[r][c] = r == c ? 8'd1 : 8'd0;
                    mb[r][c] = r == c ? 8'(r + 1) : 8'd0;
                end else if (kind == 2) begin
                    ma[r][c] = 8'd255;
                    mb[r][c] = 8'd255;
                end else begin
                    ma[r][c] = 8'($urandom_range(0, 255));
                    mb[r][c] = 8'($urandom_range(0, 255));
                end
            end
    endtask
    task automatic push_job();
        cmat_t cm;
        for (int t = 0; t < 10; t++) begin
            logic [31:0] ra, cb;
            ra = 0;
            cb = 0;
            for (int l = 0; l < 4; l++)
                if (t - l >= 0 && t - l < 4) begin
                    ra[l*8 +: 8] = ma[l][t-l];
                    cb[l*8 +: 8] = mb[t-l][l];
                end
            fq4.push_back({ra, cb});
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                cm[r*4+c] = 0;
                for (int k = 0; k < 4; k++) cm[r*4+c] += 32'(ma[r][k]) * 32'(mb[k][c]);
            end
        cq4.push_back(cm);
    endtask
    task automatic load4(input bit gaps);
        push_job();
        for (int i = 0; i < 16; i++) begin
            if (gaps)
                for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
                    f4.in_valid = 0;
                    @(posedge clk); #1;
                end
            f4.in_valid = 1;
            f4.in_a = ma[i/4][i%4];
            f4.in_b = mb[i%4][i/4];
            check("load_rdy", f4.in_ready, 1);
            @(posedge clk); #1;
            if (i == 0) check("done_drop", f4.done, 0);
        end
        f4.in_valid = 0;
    endtask
    task automatic finish4(input bit hold);
        f4.in_valid = hold;
        f4.in_a = 8'hAA;
        f4.in_b = 8'h55;
        check("clr_valid", f4.arr_valid, 0);
        check("clr_rdy", f4.in_ready, 0);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) f4.in_valid = 0;
            @(posedge clk); #1;
        end
        check("done", f4.done, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [7:0] ba [4];
        logic [7:0] bb [4];
        ba = '{8'd1, 8'd2, 8'd3, 8'd4};
        bb = '{8'd5, 8'd7, 8'd6, 8'd8};
        f2.in_valid = 0; f2.in_a = 0; f2.in_b = 0;
        f4.in_valid = 0; f4.in_a = 0; f4.in_b = 0;
        #1;
        check("rst_rdy", f4.in_ready, 1);
        check("rst_valid", f4.arr_valid, 0);
        check("rst_done", f4.done, 0);
        repeat (2) @(posedge clk);
        #1;
        nrst2 = 1;
        nrst4 = 1;
        @(posedge clk); #1;
        // N=2 worked example
        q2.push_back({16'h0001, 16'h0005});
        q2.push_back({16'h0302, 16'h0607});
        q2.push_back({16'h0400, 16'h0800});
        q2.push_back({16'h0000, 16'h0000});
        for (int i = 0; i < 4; i++) begin
            f2.in_valid = 1;
            f2.in_a = ba[i];
            f2.in_b = bb[i];
            check("n2_rdy", f2.in_ready, 1);
            @(posedge clk); #1;
        end
        f2.in_valid = 0;
        check("n2_clr_valid", f2.arr_valid, 0);
        check("n2_clr_ena", f2.arr_ena, 0);
        @(posedge clk); #1;
        for (int t = 0; t < 4; t++) begin
            logic [31:0] e;
            e = q2.pop_front();
            check("n2_row_a", f2.row_a, e[31:16]);
            check("n2_col_b", f2.col_b, e[15:0]);
            check("n2_ena", f2.arr_ena, 1);
            @(posedge clk); #1;
        end
        for (int h = 0; h < 2; h++) begin
            check("n2_done", f2.done, 1);
            check("n2_z00", z2[0][0], 19);
            check("n2_z01", z2[0][1], 22);
            check("n2_z10", z2[1][0], 43);
            check("n2_z11", z2[1][1], 50);
            repeat (10) @(posedge clk);
            #1;
        end
        // N=4 boundary: identity times diag(1..4)
        set_job(0);
        load4(0);
        finish4(0);
        repeat (3) @(posedge clk);
        #1;
        // N=4 random with input gaps, in_valid held high while busy
        set_job(1);
        load4(1);
        finish4(1);
        // reset in the middle of FEED
        set_job(1);
        load4(0);
        repeat (4) @(posedge clk);
        #1;
        nrst4 = 0;
        #1;
        check("arst_rdy", f4.in_ready, 1);
        check("arst_row_a", f4.row_a, 0);
        check("arst_col_b", f4.col_b, 0);
        check("arst_ena", f4.arr_ena, 0);
        check("arst_valid", f4.arr_valid, 0);
        check("arst_done", f4.done, 0);
        fq4.delete();
        cq4.delete();
        @(posedge clk); #1;
        nrst4 = 1;
        @(posedge clk); #1;
        check("idle_rdy", f4.in_ready, 1);
        check("idle_valid", f4.arr_valid, 0);
        // back-to-back: second job starts on the first DONE cycle
        set_job(1);
        load4(0);
        finish4(0);
        set_job(2);
        load4(0);
        finish4(0);
        repeat (3) @(posedge clk);
        #1;
        check("fq4_left", fq4.size(), 0);
        check("cq4_left", cq4.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input staging and skew stage for the N×N systolic matrix-multiply array. Accepts matrices A and B as a stream of element pairs and stores them in local registers. Clears the array accumulators, then drives the row (a) and column (b) edges of the array with diagonally skewed operands and the cell `ena`/`valid` controls. Signals `done` when every accumulator holds its final C[r][c].

## Interface
- `N`, 4, array dimension (N ≥ 2); the array has N row lanes and N column lanes
- `WIDTHx`, 8, operand width, equal to the array cell operand width
- `clock`  in  1  single clock, rising edge
- `nreset`  in  1  reset, asynchronous and active-low
- `in_valid`  in  1  load beat offered
- `in_ready`  out  1  load beat accepted when `in_valid && in_ready`
- `in_a`  in  WIDTHx  element of A; beat i = r*N+k carries A[r][k] (row-major)
- `in_b`  in  WIDTHx  element of B; beat i = c*N+k carries B[k][c] (column-major)
- `row_a`  out  N*WIDTHx  lane r in bits [r*WIDTHx +: WIDTHx], drives `a` of array row r, column 0
- `col_b`  out  N*WIDTHx  lane c in bits [c*WIDTHx +: WIDTHx], drives `b` of array column c, row 0
- `arr_ena`  out  1  broadcast cell `ena`
- `arr_valid`  out  1  broadcast cell `valid`
- `done`  out  1  level; array results are final and stable

## Operation
- Cell control encoding:
  - valid=1, ena=1: accumulate a*b
  - valid=1, ena=0: hold
  - valid=0: clear the accumulator to 0
- Storage: two N×N arrays of WIDTHx registers, A_s[r][k] and B_s[c][k].
  - Accepted beat i writes A_s[i/N][i%N] = `in_a` and B_s[i/N][i%N] = `in_b`.
- The FSM uses a load counter (0..N*N-1) and a feed counter t (0..3N-3).
- States:
  - IDLE: `in_ready`=1, `arr_valid`=0, `arr_ena`=0. On an accepted beat, store it, set the load counter to 1, and go to LOAD.
  - LOAD: `in_ready`=1, `arr_valid`=1, `arr_ena`=0 (hold). Each accepted beat increments the counter. Acceptance of beat N*N-1 goes to CLEAR.
  - CLEAR (exactly 1 cycle): `in_ready`=0, `arr_valid`=0, `arr_ena`=0. Go to FEED with t=0.
  - FEED (3N-2 cycles): `in_ready`=0, `arr_valid`=1, `arr_ena`=1.
    - Lane r of `row_a` = A_s[r][t-r] if 0 ≤ t-r < N, else 0.
    - Lane c of `col_b` = B_s[c][t-c] if 0 ≤ t-c < N, else 0.
    - After t=3N-3, go to DONE.
  - DONE: `in_ready`=1, `done`=1, `arr_valid`=1, `arr_ena`=0 (results held). An accepted beat is stored as beat 0, sets the counter to 1, and goes to LOAD. `done` deasserts in that LOAD.
- `row_a` and `col_b` are 0 in every state except FEED.
- Array-side outputs and `in_ready` decode only registered state and counters. There is no combinational path from `in_valid`, `in_a`, or `in_b` to any output.
- No arithmetic occurs here. Zero padding outside the skew window contributes 0 products, so keeping `arr_ena` high for the whole FEED is correct.

## Timing
- Reset (asynchronous, any state): go to IDLE, clear counters and storage.
  - Outputs during reset: `in_ready`=1, `row_a`=0, `col_b`=0, `arr_ena`=0, `arr_valid`=0, `done`=0.
  - Reset mid-LOAD or mid-FEED discards the partial job. The next job needs all N*N beats.
- Back-to-back beats: one beat per cycle. `in_valid` gaps stall the load counter without side effects.
- Latency: CLEAR is the cycle after the last beat is accepted. FEED occupies the next 3N-2 cycles. `done` rises on the cycle after t=3N-3, i.e. N*N + 3N - 1 cycles after the first beat when there are no gaps.
- The cell (r,c) receives its last product inputs at FEED t = r+c+N-1. The final one, cell (N-1,N-1), registers at the end of t=3N-3. Every `z` is therefore final when `done`=1.
- `in_valid` during CLEAR or FEED is not accepted (`in_ready`=0). Data must be held by the source.
- `in_valid` on the first DONE cycle is accepted; `done` is high for that one cycle only.

## Test plan
- Reset: assert `nreset`=0 mid-FEED → all outputs take reset values the same cycle; the FSM is in IDLE after release and `in_ready`=1.
- Basic N=2 load: beats (in_a, in_b) = (1,5), (2,7), (3,6), (4,8) → CLEAR shows `arr_valid`=0 for 1 cycle. FEED (lane0, lane1) values:
  - t0: `row_a` (1,0), `col_b` (5,0)
  - t1: `row_a` (2,3), `col_b` (7,6)
  - t2: `row_a` (0,4), `col_b` (0,8)
  - t3: `row_a` (0,0), `col_b` (0,0)
  - then `done`=1.
- End-to-end with the N=2 array: same stimulus → z = C = [[19,22],[43,50]] when `done`=1, and held for 10 further cycles.
- Stalls: N=4, with `in_valid` toggled randomly across 16 beats → identical FEED sequence. `in_ready`=0 through CLEAR and FEED while `in_valid`=1 is held.
- Back-to-back jobs: second job's beat 0 offered on the first DONE cycle → accepted, `done` drops. The second result is correct (e.g. all-255 A and B at N=4 give every C[r][c] = 4*65025 = 260100 with a 20-bit-or-wider accumulator) with no residue from job 1.
- Boundary: N=4, first job with identity A and B=diag(1..4) → C = diag(1..4). Check zero padding and the lane r / t-r indices at t=0 and t=3N-3.
